// File: rtl/if_load_sequencer.sv
// Sequences map-major/address-minor reads through the 8-way feature ROM mux and streams words out.
// Optional IF_LOAD_PERF_EN adds a saturating stall_cnt output.
module if_load_sequencer #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 6,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        num_maps,
  input  logic [ADDR_W:0]   words_per_map,
  output logic [2:0]        F,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_map,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef IF_LOAD_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  typedef struct packed {
    logic              last;
    logic [2:0]        map;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e              state_q, state_d;
  logic [3:0]          nmaps_q;
  logic [ADDR_W:0]     wpm_q;
  logic [2:0]          map_cnt_q, map_cnt_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic [2:0]          f_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rd_en_q, last_q, busy_q;
  logic [ROM_LAT-1:0]  tag_vld_q, tag_last_q;
  logic [ROM_LAT-1:0][2:0] tag_map_q;
  logic [CW-1:0]       inflight_q, cnt_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  entry_t              mem_q [FIFO_DEPTH];

  logic                idle, accept, issue, push, pop, credit_ok;
  logic                word_end, map_end, cur_last;
  logic [3:0]          nmaps_clamp, eff_nmaps;
  logic [ADDR_W:0]     eff_wpm;
  logic [2:0]          cur_map;
  logic [ADDR_W-1:0]   cur_word;
  entry_t              head, wr_entry;

  // In IDLE the first read is issued straight from the start inputs to save a cycle.
  assign idle        = (state_q == IDLE);
  assign accept      = idle && start;
  assign nmaps_clamp = (num_maps > 4'd8) ? 4'd8 : num_maps;
  assign eff_nmaps   = idle ? nmaps_clamp : nmaps_q;
  assign eff_wpm     = idle ? words_per_map : wpm_q;
  assign cur_map     = idle ? 3'd0 : map_cnt_q;
  assign cur_word    = idle ? '0 : word_cnt_q;
  assign word_end    = ({1'b0, cur_word} == (eff_wpm - (ADDR_W+1)'(1)));
  assign map_end     = ({1'b0, cur_map} == (eff_nmaps - 4'd1));
  assign cur_last    = word_end && map_end;
  assign credit_ok   = (({1'b0, cnt_q} + {1'b0, inflight_q}) < (CW+1)'(FIFO_DEPTH));

  assign push      = tag_vld_q[ROM_LAT-1];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign wr_entry  = '{last: tag_last_q[ROM_LAT-1], map: tag_map_q[ROM_LAT-1], data: rom_data};

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    map_cnt_d  = map_cnt_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (nmaps_clamp == 4'd0 || words_per_map == '0) begin
            state_d = FIN;
          end else begin
            issue   = 1'b1;
            state_d = cur_last ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (cur_last) state_d = DRAIN;
        end
      end
      DRAIN:   if (pop && head.last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (word_end) begin
        word_cnt_d = '0;
        map_cnt_d  = cur_map + 3'd1;
      end else begin
        word_cnt_d = cur_word + ADDR_W'(1);
        map_cnt_d  = cur_map;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nmaps_q    <= '0;
      wpm_q      <= '0;
      map_cnt_q  <= '0;
      word_cnt_q <= '0;
      f_q        <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      tag_map_q  <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      map_cnt_q  <= map_cnt_d;
      word_cnt_q <= word_cnt_d;
      if (accept) begin
        nmaps_q <= nmaps_clamp;
        wpm_q   <= words_per_map;
        busy_q  <= 1'b1;
      end else if (state_q == FIN) begin
        busy_q  <= 1'b0;
      end
      rd_en_q <= issue;
      if (issue) begin
        f_q    <= cur_map;
        addr_q <= cur_word;
        last_q <= cur_last;
      end
      // Tag rides alongside the ROM access so data lands with its map/last bits.
      tag_vld_q[0]  <= rd_en_q;
      tag_map_q[0]  <= f_q;
      tag_last_q[0] <= last_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_map_q[i]  <= tag_map_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt_q == CW'(FIFO_DEPTH)));

  assign F         = f_q;
  assign rom_addr  = addr_q;
  assign rom_rd_en = rd_en_q;
  assign out_data  = out_valid ? head.data : '0;
  assign out_map   = out_valid ? head.map : 3'd0;
  assign out_last  = out_valid && head.last;
  assign busy      = busy_q;
  assign done      = (state_q == FIN);

`ifdef IF_LOAD_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (busy_q && ((state_q == ISSUE && !credit_ok) || (out_valid && !out_ready))
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_if_load_sequencer.sv
// Randomized bench for if_load_sequencer: behavioural ROM plus map-major expected-word queue.
`timescale 1ns/1ps
module tb_if_load_sequencer;
  localparam int DATA_W = 64, ADDR_W = 6, ROM_LAT = 1, FIFO_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, rom_rd_en, out_valid, out_ready, out_last, busy, done;
  logic [3:0]        num_maps;
  logic [ADDR_W:0]   words_per_map;
  logic [2:0]        F, out_map;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data, out_data;
`ifdef IF_LOAD_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  if_load_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_maps(num_maps), .words_per_map(words_per_map),
    .F(F), .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_map(out_map),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef IF_LOAD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [DATA_W-1:0] salt = '0;

  function automatic logic [DATA_W-1:0] word_of(input logic [2:0] f, input logic [5:0] a);
    return {salt[DATA_W-1:12], 3'b000, f, a};
  endfunction

  // ROM: address/select seen in cycle c produce the word in cycle c+ROM_LAT.
  logic [9:0] pend = '0;
  logic [9:0] rpipe [ROM_LAT];
  initial for (int i = 0; i < ROM_LAT; i++) rpipe[i] = '0;
  always @(negedge clk) pend = {rom_rd_en, F, rom_addr};
  always @(posedge clk) begin
    #1;
    for (int i = ROM_LAT-1; i > 0; i--) rpipe[i] = rpipe[i-1];
    rpipe[0] = pend;
    rom_data = rpipe[ROM_LAT-1][9] ? word_of(rpipe[ROM_LAT-1][8:6], rpipe[ROM_LAT-1][5:0])
                                   : {$urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdy_mode = 0, phase = 0, first_vld_cyc = -1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (phase % 4 == 0); phase++; end
      2: out_ready = 1'($urandom % 2);
      default: out_ready = (first_vld_cyc >= 0) && (cyc >= first_vld_cyc + 10);
    endcase
  end

  logic [DATA_W+3:0] exp_q[$];
  logic [DATA_W+3:0] held, got;
  bit held_vld = 0, mon_en = 1;
  int rd_cnt, acc_cnt, max_out, last_hs_cyc, done_cnt, done_cyc, stall_model;

  always @(negedge clk) begin
    if (mon_en) begin
      got = {out_data, out_map, out_last};
      if (rom_rd_en) rd_cnt++;
      if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (held_vld) check_eq("hold_stable", got, held);
      held_vld = out_valid && !out_ready;
      held = got;
      if (busy && out_valid && !out_ready) stall_model++;
      if (out_valid && out_ready) begin
        check_eq("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check_eq("word", got, exp_q.pop_front());
        acc_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic build_exp(input int nm, input int wpm);
    int nc;
    nc = (nm > 8) ? 8 : nm;
    exp_q.delete();
    for (int m = 0; m < nc; m++)
      for (int w = 0; w < wpm; w++)
        exp_q.push_back({word_of(3'(m), 6'(w)), 3'(m), 1'(m == nc-1 && w == wpm-1)});
  endtask

  task automatic clear_stats();
    rd_cnt = 0; acc_cnt = 0; max_out = 0; first_vld_cyc = -1; last_hs_cyc = -1;
    done_cnt = 0; done_cyc = -1; stall_model = 0; held_vld = 0; phase = 0;
  endtask

  task automatic run_load(input int nm, input int wpm, input int mode, input bit dbl);
    int s, budget, n;
    n = ((nm > 8) ? 8 : nm) * wpm;
    rdy_mode = mode;
    salt = {$urandom, $urandom};
    build_exp(nm, wpm);
    clear_stats();
    num_maps = 4'(nm);
    words_per_map = 7'(wpm);
    @(posedge clk); #1;
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    num_maps = 4'($urandom); words_per_map = 7'($urandom);
    check_eq("busy_after_start", busy, 1'b1);
    if (dbl) begin
      @(posedge clk); #1 start = 1'b1; num_maps = 4'd3; words_per_map = 7'd5;
      @(posedge clk); #1 start = 1'b0;
    end
    budget = 0;
    while (done_cnt == 0 && budget < 6000) begin @(posedge clk); budget++; end
    check_eq("done_seen", done_cnt > 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_once", done_cnt, 1);
    check_eq("all_words", exp_q.size(), 0);
    check_eq("credit_bound", max_out <= FIFO_DEPTH, 1'b1);
    check_eq("busy_after_done", busy, 1'b0);
    if (n == 0) begin
      check_eq("zero_done_time", done_cyc, s + 1);
      check_eq("zero_reads", rd_cnt, 0);
      check_eq("zero_valid", first_vld_cyc, -1);
    end else begin
      check_eq("done_time", done_cyc, last_hs_cyc + 1);
      check_eq("read_count", rd_cnt, n);
      if (mode == 0) begin
        check_eq("first_valid", first_vld_cyc, s + ROM_LAT + 2);
        check_eq("throughput", last_hs_cyc - first_vld_cyc, n - 1);
      end
    end
  endtask

  initial begin
    int budget;
    bit stale;
    rst_n = 1'b0; start = 1'b0; num_maps = '0; words_per_map = '0; out_ready = 1'b1;
    rom_data = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {F, rom_addr, rom_rd_en, out_valid, out_data, out_map, out_last, busy, done}, '0);
    rst_n = 1'b1;

    run_load(2, 3, 0, 0);
    run_load(2, 3, 0, 1);
    run_load(1, 1, 0, 0);
    run_load(0, 5, 0, 0);
    run_load(3, 0, 0, 0);
    run_load(12, 2, 0, 0);
    run_load(8, 64, 1, 0);
    check_eq("credit_reaches_depth", max_out, FIFO_DEPTH);
    for (int k = 0; k < 6; k++) run_load($urandom_range(0, 10), $urandom_range(0, 9), 2, 0);

    // Reset mid-load after five accepted words.
    rdy_mode = 0;
    salt = {$urandom, $urandom};
    build_exp(3, 4);
    clear_stats();
    num_maps = 4'd3; words_per_map = 7'd4;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    budget = 0;
    while (acc_cnt < 5 && budget < 100) begin @(posedge clk); budget++; end
    check_eq("mid_load_progress", acc_cnt >= 5, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; mon_en = 0;
    @(posedge clk); #1;
    check_eq("midreset_outputs", {F, rom_addr, rom_rd_en, out_valid, out_data, out_map, out_last, busy, done}, '0);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin @(negedge clk); if (out_valid || done || rom_rd_en) stale = 1; end
    check_eq("no_stale_output", stale, 1'b0);
    exp_q.delete();
    mon_en = 1;
    run_load(1, 2, 0, 0);

`ifdef IF_LOAD_PERF_EN
    run_load(1, 4, 3, 0);
    check_eq("stall_cnt", stall_cnt, 16'(stall_model));
    check_eq("stall_min", stall_model >= 10, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("stall_hold", stall_cnt, 16'(stall_model));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
